seg_display_mux: RTL and testbench

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

---
 rtl/seg_display_mux.sv | 141 ++++++++++++++
 tb/tb_seg_display_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Multiplexed 7-segment driver: refresh prescaler, frame-synchronous double-buffered data and
// PWM dimming. Define SEG_LZ_BLANK_EN to enable leading-zero blanking.
module seg_display_mux #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned PWM_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [PWM_W-1:0]      brightness,
  output logic                  busy,
  output logic                  frame_tick,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIGITS - 1);

  logic [DIV_W-1:0]      cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [4*N_DIGITS-1:0] stage_data_q, disp_data_q;
  logic [N_DIGITS-1:0]   stage_dp_q, disp_dp_q;
  logic                  busy_q, frame_tick_q;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic       slot_tick, frame_bnd, pwm_en, blank;
  logic [3:0] nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_tick = &cnt_q;
  assign frame_bnd = slot_tick && (idx_q == LastIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + DIV_W'(1);
      frame_tick_q <= frame_bnd;
      if (slot_tick) begin
        idx_q <= frame_bnd ? '0 : idx_q + IdxW'(1);
      end
    end
  end

  // A load is only taken while nothing is staged, so a boundary either commits or stages, never both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_data_q <= '0;
      stage_dp_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      busy_q       <= 1'b0;
    end else if (!busy_q && load) begin
      stage_data_q <= data_in;
      stage_dp_q   <= dp_in;
      busy_q       <= 1'b1;
    end else if (busy_q && frame_bnd) begin
      disp_data_q <= stage_data_q;
      disp_dp_q   <= stage_dp_q;
      busy_q      <= 1'b0;
    end
  end

  assign nibble = disp_data_q[4*idx_q +: 4];
  assign pwm_en = (&brightness) || (cnt_q[DIV_W-1 -: PWM_W] < brightness);

`ifdef SEG_LZ_BLANK_EN
  logic [N_DIGITS-1:0] lz_blank;
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_above  = zero_above && (disp_data_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above && (i != 0);
    end
  end
  assign blank = lz_blank[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (pwm_en) begin
      an_d[idx_q] = 1'b0;
      seg_d       = blank ? 7'h7F : hex7(nibble);
      dp_d        = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign busy       = busy_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux (4 digits, 16-clock slots, 2-bit brightness); expected pin
// states for whole frames are queued from the decode table and popped each clock.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [1:0]  brightness;
  logic        busy, frame_tick, dp;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       ft;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  obs_t sb_q[$];

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_display_mux #(
    .N_DIGITS(4),
    .DIV_W   (4),
    .PWM_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .load      (load),
    .brightness(brightness),
    .busy      (busy),
    .frame_tick(frame_tick),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int i);
    logic [15:0] hi;
    hi = d >> (4 * i);
`ifdef SEG_LZ_BLANK_EN
    if (i > 0 && hi == 16'h0) return 7'h7F;
`endif
    return seg_lut[hi[3:0]];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    chk(tag, 16'(k < 200), 16'd1);
  endtask

  // Starts on the sample right after a frame boundary; checks the next 64 clocks.
  task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] dpv,
                             input logic [1:0] br, input logic bpre, input int load_at,
                             input logic [15:0] ld);
    obs_t e;
    int   s, p;
    logic en;
    brightness = br;
    for (int j = 0; j < 64; j++) begin
      s      = j / 16;
      p      = j % 16;
      en     = (br == 2'd3) || ((p >> 2) < int'(br));
      e.ft   = (j == 63);
      e.busy = (j == 63) ? (load_at == 62 && !bpre) : (bpre || (load_at >= 0 && j > load_at));
      e.an   = 4'hF;
      e.seg  = 7'h7F;
      e.dp   = 1'b1;
      if (en) begin
        e.an[s] = 1'b0;
        e.seg   = exp_seg(d, s);
        e.dp    = ~dpv[s];
      end
      sb_q.push_back(e);
    end
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      n_tests++;
      assert ({frame_tick, busy, an, seg, dp} === e) else begin
        n_fail++;
        $error("FAIL %s j=%0d got=%h want=%h", tag, j, {frame_tick, busy, an, seg, dp}, e);
      end
      load = (j == load_at);
      if (j == load_at) begin
        data_in = ld;
        dp_in   = 4'b0000;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    load       = 1'b0;
    data_in    = 16'h0;
    dp_in      = 4'b0;
    brightness = 2'd3;
    #12;
    chk("reset_pins", {an, seg, dp, busy, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;

    wait_frame("ft_after_reset");
    check_frame("frame_zero", 16'h0000, 4'b0000, 2'd3, 1'b0, -1, 16'h0);

    // Mid-frame load: busy next clock, old digits held until the boundary.
    repeat (20) @(negedge clk);
    data_in = 16'h81F0;
    dp_in   = 4'b0010;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_set", busy, 1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_tick) break;
      n_tests++;
      assert (seg === 7'h40 && busy === 1'b1) else begin
        n_fail++;
        $error("FAIL hold_old k=%0d got seg=%h busy=%b want seg=40 busy=1", k, seg, busy);
      end
    end
    chk("ft_hold_end", frame_tick, 1);
    chk("busy_clear", busy, 0);
    check_frame("frame_81f0", 16'h81F0, 4'b0010, 2'd3, 1'b0, -1, 16'h0);

    // Load while busy is ignored.
    repeat (5) @(negedge clk);
    data_in = 16'h81F0;
    dp_in   = 4'b0010;
    load    = 1'b1;
    @(negedge clk);
    chk("busy_reload", busy, 1);
    data_in = 16'h1234;
    dp_in   = 4'b0000;
    repeat (3) @(negedge clk);
    load = 1'b0;
    chk("busy_still", busy, 1);
    wait_frame("ft_reload");
    chk("busy_reload_clr", busy, 0);

    // Load coincident with the boundary lands one frame later.
    check_frame("frame_ignored", 16'h81F0, 4'b0010, 2'd3, 1'b0, 62, 16'h1234);
    check_frame("frame_coinc_hold", 16'h81F0, 4'b0010, 2'd3, 1'b1, -1, 16'h0);
    check_frame("frame_1234", 16'h1234, 4'b0000, 2'd3, 1'b0, -1, 16'h0);

    check_frame("frame_br1", 16'h1234, 4'b0000, 2'd1, 1'b0, -1, 16'h0);
    check_frame("frame_br0", 16'h1234, 4'b0000, 2'd0, 1'b0, 10, 16'h0050);
    check_frame("frame_0050", 16'h0050, 4'b0000, 2'd3, 1'b0, 10, 16'h0000);
    check_frame("frame_0000", 16'h0000, 4'b0000, 2'd3, 1'b0, -1, 16'h0);

    // Reset mid-slot with a capture staged.
    repeat (3) @(negedge clk);
    data_in = 16'hABCD;
    dp_in   = 4'b1111;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_pre_reset", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_pins", {an, seg, dp, busy, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_frame("ft_after_rerst");
    check_frame("frame_post_reset", 16'h0000, 4'b0000, 2'd3, 1'b0, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
